// File: rtl/titan_pkg.sv
// Shared Titan trap definitions: cause codes, trap kinds, sequencer states,
// mtvec mode encodings and the trap-vector target helper.
package titan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    TRAP_EXC  = 2'd0,
    TRAP_INT  = 2'd1,
    TRAP_XRET = 2'd2
  } trap_kind_e;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  localparam logic [3:0] EXC_INSN_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_INSN_ILLEGAL  = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT    = 4'd3;
  localparam logic [3:0] EXC_LOAD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_STORE_FAULT   = 4'd7;
  localparam logic [3:0] EXC_ECALL_M       = 4'd11;

  localparam logic [3:0] INT_SW_M    = 4'd3;
  localparam logic [3:0] INT_TIMER_M = 4'd7;
  localparam logic [3:0] INT_EXT_M   = 4'd11;

  // Modes 10/11 are reserved and fall back to direct; the add wraps mod 2^32.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        is_int,
                                              input logic [3:0]  code,
                                              input logic        vec_en);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (vec_en && is_int && (mtvec[1:0] == MTVEC_VECTORED))
      return base + {26'd0, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/titan_trap_sequencer_if.sv
// Request, CSR-commit and fetch-redirect signals between the core and the
// trap sequencer. master = core side, slave = sequencer.
interface titan_trap_sequencer_if;
  logic        exc_req_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_pc_i;
  logic [31:0] exc_tval_i;
  logic        xret_req_i;
  logic        int_pending_i;
  logic [3:0]  int_cause_i;
  logic [31:0] int_pc_i;
  logic        mem_busy_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        redirect_ready_i;

  logic        stall_o;
  logic        flush_o;
  logic        trap_commit_o;
  logic        xret_commit_o;
  logic [31:0] trap_cause_o;
  logic [31:0] trap_pc_o;
  logic [31:0] trap_tval_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        busy_o;

  modport master (
    output exc_req_i, exc_cause_i, exc_pc_i, exc_tval_i, xret_req_i,
           int_pending_i, int_cause_i, int_pc_i, mem_busy_i, mtvec_i,
           mepc_i, redirect_ready_i,
    input  stall_o, flush_o, trap_commit_o, xret_commit_o, trap_cause_o,
           trap_pc_o, trap_tval_o, redirect_valid_o, redirect_pc_o, busy_o
  );

  modport slave (
    input  exc_req_i, exc_cause_i, exc_pc_i, exc_tval_i, xret_req_i,
           int_pending_i, int_cause_i, int_pc_i, mem_busy_i, mtvec_i,
           mepc_i, redirect_ready_i,
    output stall_o, flush_o, trap_commit_o, xret_commit_o, trap_cause_o,
           trap_pc_o, trap_tval_o, redirect_valid_o, redirect_pc_o, busy_o
  );
endinterface

// File: rtl/titan_trap_sequencer.sv
// Trap entry / xRET sequencer: accept one event, drain the data bus, pulse the
// CSR commit, then hand fetch a redirect PC over valid/ready.
module titan_trap_sequencer
  import titan_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter bit          VECTORED_EN  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  titan_trap_sequencer_if.slave  bus
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  seq_state_e  state_q, state_d;
  trap_kind_e  kind_q, kind_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] tgt_q, tgt_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      kind_q  <= TRAP_EXC;
      code_q  <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    kind_d               = kind_q;
    code_d               = code_q;
    pc_d                 = pc_q;
    tval_d               = tval_q;
    cnt_d                = cnt_q;
    tgt_d                = tgt_q;
    bus.stall_o          = 1'b0;
    bus.flush_o          = 1'b0;
    bus.trap_commit_o    = 1'b0;
    bus.xret_commit_o    = 1'b0;
    bus.redirect_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Priority exc > xret > int; a losing interrupt is simply re-sampled later.
        if (bus.exc_req_i) begin
          kind_d  = TRAP_EXC;
          code_d  = bus.exc_cause_i;
          pc_d    = bus.exc_pc_i & 32'hFFFF_FFFC;
          tval_d  = bus.exc_tval_i;
          cnt_d   = DRAIN_INIT;
          state_d = ST_DRAIN;
          bus.stall_o = 1'b1;
        end else if (bus.xret_req_i) begin
          kind_d  = TRAP_XRET;
          code_d  = '0;
          pc_d    = '0;
          tval_d  = '0;
          cnt_d   = DRAIN_INIT;
          state_d = ST_DRAIN;
          bus.stall_o = 1'b1;
        end else if (bus.int_pending_i) begin
          kind_d  = TRAP_INT;
          code_d  = bus.int_cause_i;
          pc_d    = bus.int_pc_i & 32'hFFFF_FFFC;
          tval_d  = '0;
          cnt_d   = DRAIN_INIT;
          state_d = ST_DRAIN;
          bus.stall_o = 1'b1;
        end
      end
      ST_DRAIN: begin
        bus.stall_o = 1'b1;
        bus.flush_o = 1'b1;
        if (cnt_q != 4'd0)
          cnt_d = cnt_q - 4'd1;
        else if (!bus.mem_busy_i)
          state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        bus.stall_o = 1'b1;
        if (kind_q == TRAP_XRET) begin
          bus.xret_commit_o = 1'b1;
          tgt_d = bus.mepc_i & 32'hFFFF_FFFC;
        end else begin
          bus.trap_commit_o = 1'b1;
          tgt_d = trap_target(bus.mtvec_i, kind_q == TRAP_INT, code_q, VECTORED_EN);
        end
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        bus.stall_o          = 1'b1;
        bus.redirect_valid_o = 1'b1;
        if (bus.redirect_ready_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o        = (state_q != ST_IDLE);
    bus.trap_cause_o  = '0;
    bus.trap_pc_o     = '0;
    bus.trap_tval_o   = '0;
    bus.redirect_pc_o = '0;
    if (state_q != ST_IDLE) begin
      bus.trap_cause_o = {kind_q == TRAP_INT, 27'd0, code_q};
      bus.trap_pc_o    = pc_q;
      bus.trap_tval_o  = tval_q;
    end
    if (state_q == ST_REDIRECT)
      bus.redirect_pc_o = tgt_q;
  end

endmodule

// File: tb/tb_titan_trap_sequencer.sv
// Directed bench for titan_trap_sequencer (DRAIN_CYCLES=2, VECTORED_EN=1).
module tb_titan_trap_sequencer;
  import titan_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  titan_trap_sequencer_if bus();

  titan_trap_sequencer #(.DRAIN_CYCLES(2), .VECTORED_EN(1'b1)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick(); @(posedge clk_i); #1; endtask
  task automatic smp();  @(negedge clk_i); endtask

  task automatic clr_reqs();
    bus.exc_req_i     = 1'b0;
    bus.xret_req_i    = 1'b0;
    bus.int_pending_i = 1'b0;
  endtask

  // Samples from the current cycle onward until a commit pulse; returns its cycle index or -1.
  task automatic go_commit(input int start, output int n);
    n = -1;
    for (int i = start; i < start + 40; i++) begin
      smp();
      if (bus.trap_commit_o || bus.xret_commit_o) begin n = i; return; end
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({bus.busy_o, bus.stall_o, bus.flush_o, bus.trap_commit_o, bus.xret_commit_o, bus.redirect_valid_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {bus.busy_o, bus.stall_o, bus.flush_o, bus.trap_commit_o, bus.xret_commit_o, bus.redirect_valid_o}); end
    checks++; if ({bus.trap_cause_o, bus.trap_pc_o, bus.trap_tval_o, bus.redirect_pc_o} !== 128'b0) begin
      errors++; $display("FAIL reset_data got %h want 0", {bus.trap_cause_o, bus.trap_pc_o, bus.trap_tval_o, bus.redirect_pc_o}); end
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_exception();
    tick();
    bus.exc_req_i = 1; bus.exc_cause_i = 4'd2; bus.exc_pc_i = 32'h100; bus.exc_tval_i = 32'hDEAD; bus.mtvec_i = 32'h200;
    smp();
    checks++; if ({bus.stall_o, bus.flush_o, bus.busy_o} !== 3'b100) begin
      errors++; $display("FAIL exc_c0 got stall/flush/busy=%b want 100", {bus.stall_o, bus.flush_o, bus.busy_o}); end
    tick(); clr_reqs();
    for (int c = 1; c <= 2; c++) begin
      smp();
      checks++; if ({bus.stall_o, bus.flush_o, bus.trap_commit_o} !== 3'b110) begin
        errors++; $display("FAIL exc_drain_c%0d got %b want 110", c, {bus.stall_o, bus.flush_o, bus.trap_commit_o}); end
      tick();
    end
    smp();
    checks++; if ({bus.trap_commit_o, bus.xret_commit_o, bus.flush_o} !== 3'b100) begin
      errors++; $display("FAIL exc_commit_c3 got %b want 100", {bus.trap_commit_o, bus.xret_commit_o, bus.flush_o}); end
    checks++; if ({bus.trap_cause_o, bus.trap_pc_o, bus.trap_tval_o} !== {32'h2, 32'h100, 32'hDEAD}) begin
      errors++; $display("FAIL exc_capture got %h/%h/%h want 00000002/00000100/0000dead", bus.trap_cause_o, bus.trap_pc_o, bus.trap_tval_o); end
    tick(); smp();
    checks++; if (!(bus.redirect_valid_o === 1'b1 && bus.redirect_pc_o === 32'h200 && bus.trap_commit_o === 1'b0)) begin
      errors++; $display("FAIL exc_redirect_c4 got v=%b pc=%h want v=1 pc=00000200", bus.redirect_valid_o, bus.redirect_pc_o); end
    tick(); smp();
    checks++; if ({bus.busy_o, bus.redirect_valid_o, bus.stall_o} !== 3'b000) begin
      errors++; $display("FAIL exc_idle got %b want 000", {bus.busy_o, bus.redirect_valid_o, bus.stall_o}); end
  endtask

  task automatic test_vectored_int();
    int n;
    tick();
    bus.int_pending_i = 1; bus.int_cause_i = 4'd7; bus.int_pc_i = 32'h88; bus.mtvec_i = 32'h401;
    smp();
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL int_c0_stall got %b want 1", bus.stall_o); end
    tick(); clr_reqs();
    go_commit(1, n);
    checks++; if (n != 3) begin errors++; $display("FAIL int_commit_cycle got %0d want 3", n); end
    checks++; if ({bus.trap_cause_o, bus.trap_pc_o, bus.trap_tval_o} !== {32'h8000_0007, 32'h88, 32'h0}) begin
      errors++; $display("FAIL int_capture got %h/%h/%h want 80000007/00000088/00000000", bus.trap_cause_o, bus.trap_pc_o, bus.trap_tval_o); end
    tick(); smp();
    checks++; if (bus.redirect_pc_o !== 32'h41C) begin errors++; $display("FAIL int_vector_pc got %h want 0000041c", bus.redirect_pc_o); end
    tick();
  endtask

  task automatic test_mret();
    int n;
    tick();
    bus.xret_req_i = 1; bus.mepc_i = 32'h1236;
    smp();
    tick(); clr_reqs();
    go_commit(1, n);
    checks++; if (!(n == 3 && bus.xret_commit_o === 1'b1 && bus.trap_commit_o === 1'b0)) begin
      errors++; $display("FAIL mret_commit got n=%0d x=%b t=%b want n=3 x=1 t=0", n, bus.xret_commit_o, bus.trap_commit_o); end
    tick(); smp();
    checks++; if (bus.redirect_pc_o !== 32'h1234) begin errors++; $display("FAIL mret_pc got %h want 00001234", bus.redirect_pc_o); end
    tick();
  endtask

  task automatic test_priority();
    int n;
    tick();
    bus.exc_req_i = 1; bus.exc_cause_i = 4'd11; bus.exc_pc_i = 32'h40; bus.exc_tval_i = 32'h0;
    bus.int_pending_i = 1; bus.int_cause_i = 4'd3; bus.int_pc_i = 32'h300; bus.mtvec_i = 32'h200;
    smp();
    tick(); bus.exc_req_i = 0;
    go_commit(1, n);
    checks++; if (!(n == 3 && bus.trap_cause_o === 32'h0000_000B)) begin
      errors++; $display("FAIL prio_cause got n=%0d cause=%h want n=3 cause=0000000b", n, bus.trap_cause_o); end
    tick(); smp(); tick(); smp();
    checks++; if ({bus.busy_o, bus.stall_o} !== 2'b01) begin
      errors++; $display("FAIL prio_int_retaken got busy/stall=%b want 01", {bus.busy_o, bus.stall_o}); end
    tick(); clr_reqs();
    go_commit(1, n);
    checks++; if (!(n == 3 && bus.trap_cause_o === 32'h8000_0003 && bus.trap_pc_o === 32'h300)) begin
      errors++; $display("FAIL prio_int_commit got n=%0d cause=%h pc=%h want 3/80000003/00000300", n, bus.trap_cause_o, bus.trap_pc_o); end
    tick(); smp();
    checks++; if (bus.redirect_pc_o !== 32'h200) begin errors++; $display("FAIL prio_direct_pc got %h want 00000200", bus.redirect_pc_o); end
    tick();
  endtask

  task automatic test_mem_busy();
    tick();
    bus.exc_req_i = 1; bus.exc_cause_i = 4'd5; bus.exc_pc_i = 32'h503; bus.exc_tval_i = 32'h77; bus.mtvec_i = 32'hFFFF_FFF5;
    smp();
    tick(); clr_reqs(); bus.mem_busy_i = 1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) bus.mem_busy_i = 0;
      smp();
      checks++; if ({bus.flush_o, bus.trap_commit_o} !== 2'b10) begin
        errors++; $display("FAIL busy_drain_c%0d got %b want 10", c, {bus.flush_o, bus.trap_commit_o}); end
      tick();
    end
    smp();
    checks++; if (!(bus.trap_commit_o === 1'b1 && bus.trap_pc_o === 32'h500)) begin
      errors++; $display("FAIL busy_commit_c7 got t=%b pc=%h want 1/00000500", bus.trap_commit_o, bus.trap_pc_o); end
    tick(); smp();
    checks++; if (bus.redirect_pc_o !== 32'hFFFF_FFF4) begin errors++; $display("FAIL busy_exc_direct got %h want fffffff4", bus.redirect_pc_o); end
    tick();
  endtask

  task automatic test_vector_wrap();
    int n;
    tick();
    bus.int_pending_i = 1; bus.int_cause_i = 4'd11; bus.int_pc_i = 32'h10; bus.mtvec_i = 32'hFFFF_FFE1;
    smp();
    tick(); clr_reqs();
    go_commit(1, n);
    tick(); smp();
    checks++; if (bus.redirect_pc_o !== 32'h0000_000C) begin errors++; $display("FAIL wrap_pc got %h want 0000000c", bus.redirect_pc_o); end
    tick();
    bus.int_pending_i = 1; bus.int_cause_i = 4'd7; bus.mtvec_i = 32'h803;
    smp();
    tick(); clr_reqs();
    go_commit(1, n);
    tick(); smp();
    checks++; if (bus.redirect_pc_o !== 32'h800) begin errors++; $display("FAIL mode11_pc got %h want 00000800", bus.redirect_pc_o); end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    bus.redirect_ready_i = 0;
    tick();
    bus.exc_req_i = 1; bus.exc_cause_i = 4'd3; bus.exc_pc_i = 32'h20; bus.mtvec_i = 32'h600;
    smp();
    tick(); clr_reqs();
    go_commit(1, n);
    for (int c = 4; c <= 6; c++) begin
      tick(); smp();
      checks++; if (!(bus.redirect_valid_o === 1'b1 && bus.redirect_pc_o === 32'h600)) begin
        errors++; $display("FAIL bp_hold_c%0d got v=%b pc=%h want 1/00000600", c, bus.redirect_valid_o, bus.redirect_pc_o); end
    end
    tick(); bus.redirect_ready_i = 1; smp();
    checks++; if (!(bus.redirect_valid_o === 1'b1 && bus.redirect_pc_o === 32'h600)) begin
      errors++; $display("FAIL bp_accept got v=%b pc=%h want 1/00000600", bus.redirect_valid_o, bus.redirect_pc_o); end
    tick(); smp();
    checks++; if ({bus.busy_o, bus.redirect_valid_o} !== 2'b00) begin
      errors++; $display("FAIL bp_release got %b want 00", {bus.busy_o, bus.redirect_valid_o}); end
  endtask

  task automatic test_reset_mid_drain();
    tick();
    bus.exc_req_i = 1; bus.exc_cause_i = 4'd2; bus.exc_pc_i = 32'h900; bus.exc_tval_i = 32'h5; bus.mtvec_i = 32'h200;
    smp();
    tick(); clr_reqs(); bus.mem_busy_i = 1;
    smp();
    checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL rst_pre_drain got flush=%b want 1", bus.flush_o); end
    #2 rst_i = 1'b0;
    #1;
    checks++; if ({bus.busy_o, bus.stall_o, bus.flush_o, bus.trap_cause_o, bus.trap_pc_o, bus.trap_tval_o} !== 99'b0) begin
      errors++; $display("FAIL rst_mid_drain got busy=%b stall=%b flush=%b pc=%h want all 0", bus.busy_o, bus.stall_o, bus.flush_o, bus.trap_pc_o); end
    bus.mem_busy_i = 0;
    @(negedge clk_i); rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); smp();
      checks++; if ({bus.busy_o, bus.trap_commit_o, bus.redirect_valid_o} !== 3'b000) begin
        errors++; $display("FAIL rst_after_c%0d got %b want 000", c, {bus.busy_o, bus.trap_commit_o, bus.redirect_valid_o}); end
    end
  endtask

  initial begin
    clr_reqs();
    bus.exc_cause_i = '0; bus.exc_pc_i = '0; bus.exc_tval_i = '0;
    bus.int_cause_i = '0; bus.int_pc_i = '0; bus.mem_busy_i = 1'b0;
    bus.mtvec_i = '0; bus.mepc_i = '0; bus.redirect_ready_i = 1'b1;
    test_reset();
    test_exception();
    test_vectored_int();
    test_mret();
    test_priority();
    test_mem_busy();
    test_vector_wrap();
    test_backpressure();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
